// File: rtl/seg_pkg.sv
// Shared types and constants for the multiplexed 8-digit hex display scanner.
package seg_pkg;

  typedef enum logic {
    SHOW  = 1'b0,
    BLANK = 1'b1
  } state_t;

  localparam int unsigned NUM_DIGITS = 8;
  localparam logic [7:0]  AN_OFF     = 8'hFF;

  // Leading-zero test: digit idx and every digit above it carry a zero nibble and no dp.
  function automatic logic lz_hidden(input logic [2:0]  idx,
                                     input logic [31:0] data,
                                     input logic [7:0]  dp);
    logic zero;
    zero = 1'b1;
    for (int i = 1; i < NUM_DIGITS; i++) begin
      if (i >= int'(idx)) begin
        zero = zero & (data[4*i +: 4] == 4'h0) & ~dp[i];
      end
    end
    return (idx != 3'd0) && zero;
  endfunction

endpackage

// File: rtl/seg_tick_gen.sv
// Slot timing: lit-time prescaler running in SHOW and blank-interval counter running in BLANK.
module seg_tick_gen
  import seg_pkg::*;
#(
  parameter int unsigned REFRESH_DIV  = 100000,
  parameter int unsigned BLANK_CYCLES = 16
) (
  input  logic   clk,
  input  logic   rst,
  input  state_t state,
  output logic   tick,
  output logic   blank_done
);

  localparam int unsigned CW = $clog2(REFRESH_DIV);
  localparam int unsigned BW = (BLANK_CYCLES > 1) ? $clog2(BLANK_CYCLES) : 1;

  logic [CW-1:0] cnt;
  logic [BW-1:0] bcnt;

  assign tick       = (state == SHOW)  && (cnt  == CW'(REFRESH_DIV - 1));
  assign blank_done = (state == BLANK) && (bcnt == BW'(BLANK_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt  <= '0;
      bcnt <= '0;
    end else begin
      if (state == SHOW && !tick) cnt <= cnt + CW'(1);
      else                        cnt <= '0;
      if (state == BLANK && !blank_done) bcnt <= bcnt + BW'(1);
      else                               bcnt <= '0;
    end
  end

endmodule

// File: rtl/seg_scan_ctrl.sv
// Eight-digit multiplexed display scanner with frame-atomic double buffering and
// optional leading-zero suppression.
//   state | meaning
//   SHOW  | anode idx driven low (unless suppressed) for REFRESH_DIV cycles
//   BLANK | all anodes off for BLANK_CYCLES cycles, then advance idx
module seg_scan_ctrl
  import seg_pkg::*;
#(
  parameter int unsigned REFRESH_DIV  = 100000,
  parameter int unsigned BLANK_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] data_in,
  input  logic [7:0]  dp_in,
  input  logic        load,
  input  logic        blank_lz,
  output logic [7:0]  an,
  output logic [3:0]  nibble,
  output logic        dp_n,
  output logic        frame_done
);

  state_t      state, state_next;
  logic [2:0]  idx, idx_next;
  logic        tick, blank_done, wrap;
  logic [31:0] shadow_data, active_data, active_data_next;
  logic [7:0]  shadow_dp, active_dp, active_dp_next;
  logic [7:0]  an_next;

  seg_tick_gen #(
    .REFRESH_DIV (REFRESH_DIV),
    .BLANK_CYCLES(BLANK_CYCLES)
  ) u_tick_gen (
    .clk       (clk),
    .rst       (rst),
    .state     (state),
    .tick      (tick),
    .blank_done(blank_done)
  );

  always_comb begin
    state_next       = state;
    idx_next         = idx;
    wrap             = 1'b0;
    active_data_next = active_data;
    active_dp_next   = active_dp;
    an_next          = AN_OFF;
    case (state)
      SHOW: begin
        if (tick) state_next = BLANK;
      end
      BLANK: begin
        if (blank_done) begin
          state_next = SHOW;
          idx_next   = idx + 3'd1;
          wrap       = (idx == 3'd7);
        end
      end
      default: state_next = BLANK;
    endcase
    // A load on the wrap edge itself must reach the new frame, so bypass the shadow.
    if (wrap) begin
      active_data_next = load ? data_in : shadow_data;
      active_dp_next   = load ? dp_in   : shadow_dp;
    end
    if (state_next == SHOW &&
        !(blank_lz && lz_hidden(idx_next, active_data_next, active_dp_next))) begin
      an_next[idx_next] = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= BLANK;
      idx         <= 3'd7;
      shadow_data <= '0;
      shadow_dp   <= '0;
      active_data <= '0;
      active_dp   <= '0;
      an          <= AN_OFF;
      nibble      <= 4'h0;
      dp_n        <= 1'b1;
      frame_done  <= 1'b0;
    end else begin
      state       <= state_next;
      idx         <= idx_next;
      active_data <= active_data_next;
      active_dp   <= active_dp_next;
      an          <= an_next;
      frame_done  <= wrap;
      if (load) begin
        shadow_data <= data_in;
        shadow_dp   <= dp_in;
      end
      // nibble and dp_n hold through BLANK so the segment bus stays quiet.
      if (state_next == SHOW) begin
        nibble <= active_data_next[{idx_next, 2'b00} +: 4];
        dp_n   <= ~active_dp_next[idx_next];
      end
    end
  end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Self-checking bench for seg_scan_ctrl: directed scenarios then random traffic vs a timeline model.
module tb_seg_scan_ctrl;

  localparam int RD   = 4;
  localparam int BC   = 2;
  localparam int SLOT = RD + BC;
  localparam int PER  = 8 * SLOT;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] data_in = '0;
  logic [7:0]  dp_in = '0;
  logic        load = 1'b0;
  logic        blank_lz = 1'b0;
  logic [7:0]  an;
  logic [3:0]  nibble;
  logic        dp_n;
  logic        frame_done;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model state: edges since reset release, shadow/active frame contents.
  int          k = 0;
  logic [31:0] sh_d = '0, ac_d = '0;
  logic [7:0]  sh_p = '0, ac_p = '0;
  logic [7:0]  e_an = 8'hFF;
  logic [3:0]  e_nib = 4'h0;
  logic        e_dpn = 1'b1;
  logic        e_fd = 1'b0;

  seg_scan_ctrl #(
    .REFRESH_DIV (RD),
    .BLANK_CYCLES(BC)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .data_in   (data_in),
    .dp_in     (dp_in),
    .load      (load),
    .blank_lz  (blank_lz),
    .an        (an),
    .nibble    (nibble),
    .dp_n      (dp_n),
    .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", tag, obs, exp, $time);
    end
  endtask

  // Timeline model: after release, edge 2 starts frame 0; each frame is 8 slots of RD lit + BC dark.
  task automatic model_edge();
    int m, slot, w;
    if (rst) begin
      k = 0;
      sh_d = '0; sh_p = '0; ac_d = '0; ac_p = '0;
      e_an = 8'hFF; e_nib = 4'h0; e_dpn = 1'b1; e_fd = 1'b0;
    end else begin
      k++;
      if (load) begin
        sh_d = data_in;
        sh_p = dp_in;
      end
      e_fd = 1'b0;
      e_an = 8'hFF;
      if (k >= 2) begin
        m    = (k - 2) % PER;
        slot = m / SLOT;
        w    = m % SLOT;
        if (m == 0) begin
          ac_d = sh_d;
          ac_p = sh_p;
          e_fd = 1'b1;
        end
        if (w < RD) begin
          e_nib = 4'((ac_d >> (4 * slot)) & 32'hF);
          e_dpn = ~ac_p[slot];
          if (!(blank_lz && slot != 0 && (ac_d >> (4 * slot)) == 0 && (ac_p >> slot) == 0))
            e_an = ~(8'd1 << slot);
        end
      end
    end
  endtask

  task automatic cyc(input logic r, input logic ld, input logic [31:0] d,
                     input logic [7:0] p, input logic lz);
    rst = r; load = ld; data_in = d; dp_in = p; blank_lz = lz;
    @(posedge clk);
    model_edge();
    #1;
    chk("an", an, e_an);
    chk("nibble", nibble, e_nib);
    chk("dp_n", dp_n, e_dpn);
    chk("frame_done", frame_done, e_fd);
    chk("one_anode_max", ($countones(~an) <= 1), 1);
  endtask

  task automatic idle(input int n, input logic lz);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, $urandom, 8'($urandom), lz);
  endtask

  initial begin
    logic lz;
    // Reset, with a load asserted alongside it that must be ignored.
    cyc(1'b1, 1'b0, 32'h0, 8'h0, 1'b0);
    cyc(1'b1, 1'b1, 32'hDEADBEEF, 8'hFF, 1'b0);
    chk("rst_an", an, 8'hFF);
    chk("rst_nibble", nibble, 4'h0);
    cyc(1'b1, 1'b0, 32'h0, 8'h0, 1'b0);

    // Basic scan with 89ABCDEF loaded on the first post-reset edge.
    cyc(1'b0, 1'b1, 32'h89ABCDEF, 8'h00, 1'b0);
    cyc(1'b0, 1'b0, 32'h0, 8'h0, 1'b0);
    chk("first_wrap_fd", frame_done, 1'b1);
    chk("first_wrap_an", an, 8'hFE);
    chk("first_wrap_nib", nibble, 4'hF);
    idle(2 * PER, 1'b0);

    // Frame atomicity: zeros become active, then a mid-frame load of 12345678.
    idle(PER / 3, 1'b0);
    cyc(1'b0, 1'b1, 32'h00000000, 8'h00, 1'b0);
    while ((k - 1) % PER != 0) cyc(1'b0, 1'b0, 32'h0, 8'h0, 1'b0);
    idle(PER / 2, 1'b0);
    cyc(1'b0, 1'b1, 32'h12345678, 8'h00, 1'b0);
    idle(2 * PER, 1'b0);

    // Leading-zero suppression cases.
    cyc(1'b0, 1'b1, 32'h00000A05, 8'h00, 1'b1);
    idle(2 * PER, 1'b1);
    cyc(1'b0, 1'b1, 32'h00000000, 8'h04, 1'b1);
    idle(2 * PER, 1'b1);

    // Load exactly on the wrap edge overrides an older shadow value.
    cyc(1'b0, 1'b1, 32'h00000055, 8'h00, 1'b0);
    while ((k - 1) % PER != 0) cyc(1'b0, 1'b0, 32'h0, 8'h0, 1'b0);
    cyc(1'b0, 1'b1, 32'h0000000C, 8'h00, 1'b0);
    chk("wrap_load_fd", frame_done, 1'b1);
    chk("wrap_load_nib", nibble, 4'hC);
    idle(PER, 1'b0);

    // Reset while digit 3 is lit, load held high throughout.
    while (!(k >= 2 && ((k - 2) % PER) / SLOT == 3 && ((k - 2) % PER) % SLOT < RD))
      cyc(1'b0, 1'b0, 32'h0, 8'h0, 1'b0);
    cyc(1'b1, 1'b1, 32'hFFFFFFFF, 8'hFF, 1'b0);
    chk("midrst_an", an, 8'hFF);
    chk("midrst_dpn", dp_n, 1'b1);
    cyc(1'b1, 1'b1, 32'hFFFFFFFF, 8'hFF, 1'b0);
    idle(2, 1'b0);
    chk("midrst_d0_an", an, 8'hFE);
    chk("midrst_d0_nib", nibble, 4'h0);
    idle(PER, 1'b0);

    // Random traffic, occasional resets and blank_lz changes.
    lz = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 199) == 0) lz = ~lz;
      cyc(($urandom_range(0, 599) == 0),
          ($urandom_range(0, 15) == 0),
          ($urandom_range(0, 1) == 1) ? $urandom : ($urandom & 32'h00000F0F),
          ($urandom_range(0, 2) == 0) ? 8'($urandom) : 8'h00,
          lz);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/seg_scan_ctrl.md
SEG_SCAN_CTRL -- requirements
Module: seg_scan_ctrl

Interface
REQ-001 Parameter: REFRESH_DIV, 100000, clock cycles each digit is lit per scan slot (minimum 2).
REQ-002 Parameter: BLANK_CYCLES, 16, anti-ghosting interval with all anodes off between digits (minimum 1).
REQ-003 clk  input  1  single system clock; all logic on its rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 data_in  input  32  eight hex nibbles; digit i = data_in[4i+3:4i], digit 0 rightmost.
REQ-006 dp_in  input  8  decimal-point request per digit, active-high; bit i = digit i.
REQ-007 load  input  1  single-cycle strobe; captures data_in and dp_in.
REQ-008 blank_lz  input  1  level; enables leading-zero suppression.
REQ-009 an  output  8  digit anode enables, active-low; at most one bit low at any time.
REQ-010 nibble  output  4  hex value of the selected digit; feeds the downstream hex-to-segment decoder.
REQ-011 dp_n  output  1  decimal point for the selected digit, active-low.
REQ-012 frame_done  output  1  one-cycle pulse when the scan wraps from digit 7 to digit 0.

Function
REQ-013 Prescaler: cnt counts 0..REFRESH_DIV-1 in SHOW; tick asserted when cnt = REFRESH_DIV-1.
REQ-014 FSM states SHOW and BLANK; SHOW -> BLANK on tick; BLANK -> SHOW after exactly BLANK_CYCLES cycles in BLANK.
REQ-015 On the BLANK -> SHOW transition, idx (3-bit) increments modulo 8; 7 wraps to 0.
REQ-016 In SHOW, an = all ones except bit idx = 0, unless idx is suppressed (REQ-021).
REQ-017 In BLANK, an = 8'hFF, nibble and dp_n hold their last SHOW values.
REQ-018 nibble and dp_n come from the active register, not directly from data_in/dp_in; dp_n = ~active_dp[idx].
REQ-019 load = 1 writes data_in/dp_in into the shadow register on that edge; the last load before a wrap wins.
REQ-020 Active register updates only on the wrap edge (idx 7 -> 0); value = data_in/dp_in when load is asserted on that same edge, else shadow; frame_done pulses on that cycle; a displayed frame never mixes old and new data.
REQ-021 blank_lz = 1: digit i (i >= 1) is suppressed (its anode stays 1) when active nibbles i..7 are all zero and active_dp[i..7] are all zero; digit 0 is never suppressed.
REQ-022 Suppressed slots keep full SHOW/BLANK timing; the scan period is constant at 8*(REFRESH_DIV+BLANK_CYCLES) cycles.
REQ-023 All outputs are registered; an, nibble and dp_n change on the same edge.

Reset
REQ-024 rst = 1 on a clock edge: state = BLANK, BLANK counter = 0, cnt = 0, idx = 7, shadow and active = 0, dp registers = 0.
REQ-025 During reset: an = 8'hFF, nibble = 4'h0, dp_n = 1, frame_done = 0.
REQ-026 After rst deasserts: BLANK_CYCLES blank cycles, then the wrap to idx 0 with frame_done = 1 and SHOW of digit 0; load is honoured from the first post-reset edge.
REQ-027 Reset mid-scan aborts immediately and discards shadow contents; load asserted together with rst is ignored.

Structure
REQ-028 Shared package seg_pkg holds: state enum type (SHOW, BLANK), NUM_DIGITS = 8, an-off constant 8'hFF.
REQ-029 Prescaler/blank counter is a natural sub-module, seg_tick_gen (outputs tick and blank_done); scan FSM and registers stay in seg_scan_ctrl.
REQ-030 The hex-to-segment decoder is not instantiated here; integration connects nibble/dp_n to it at top level.

Verification (REFRESH_DIV = 4, BLANK_CYCLES = 2)
REQ-031 Reset, load 32'h89ABCDEF, dp_in 8'h00 -> after first wrap an cycles FE,FF,FD,FF,...,7F with nibble F,E,D,...,8; each low-anode window 4 cycles, each blank 2 cycles; frame_done every 48 cycles.
REQ-032 Load 32'h00000000 then 32'h12345678 mid-frame -> current frame shows all zeros; next frame shows 1..8; no frame mixes values.
REQ-033 blank_lz = 1, active 32'h00000A05 -> digits 3..7 anodes stay high; digits 0,1,2 shown as 5,0,A; period still 48 cycles.
REQ-034 blank_lz = 1, data 0, dp_in 8'h04 -> digits 0..2 lit with dp_n = 0 only on digit 2; digits 3..7 suppressed.
REQ-035 rst asserted with idx = 3 in SHOW, load held high -> next edge an = FF, nibble = 0, dp_n = 1; after release digit 0 shows 0.
REQ-036 Load asserted exactly on the wrap edge with 32'h0000000C -> that new frame shows C on digit 0, not the older shadow value.
